// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Shares the register-file write port between WB and a FIFO of LU results.
// Revision : 1.0
// ============================================================================
module regfile_write_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        wb_stall,
    input  logic        lu_valid,
    input  logic [4:0]  lu_rd,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wdata,
    output logic [31:0] pending_mask
);

    localparam int C_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int C_CNT_W = C_PTR_W + 1;
    localparam int C_STV_W = $clog2(STARVE_MAX + 1);

    localparam logic [C_CNT_W-1:0] C_DEPTH  = C_CNT_W'(DEPTH);
    localparam logic [C_STV_W-1:0] C_STARVE = C_STV_W'(STARVE_MAX);

    logic [4:0]         r_fifo_rd   [DEPTH];
    logic [31:0]        r_fifo_data [DEPTH];
    logic [DEPTH-1:0]   r_fifo_vld;
    logic [C_PTR_W-1:0] r_wptr;
    logic [C_PTR_W-1:0] r_rptr;
    logic [C_CNT_W-1:0] r_count;
    logic [C_STV_W-1:0] r_starve;

    logic        w_not_empty;
    logic        w_force;
    logic        w_wb_req;
    logic        w_grant_wb;
    logic        w_grant_lu;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_pending;

    // All handshake outputs come from registered state only, so no comb path WB/LU -> ready/stall.
    assign w_not_empty = (r_count != '0);
    assign w_force     = (r_starve == C_STARVE) && w_not_empty;
    assign lu_ready    = (r_count < C_DEPTH);
    assign wb_stall    = w_force;

    assign w_wb_req   = wb_valid && (wb_rd != 5'd0);
    assign w_grant_wb = !w_force && w_wb_req;
    assign w_grant_lu = w_force || (!w_wb_req && w_not_empty);
    assign w_pop      = w_grant_lu;
    // x0 results complete the handshake but never occupy an entry.
    assign w_push     = lu_valid && lu_ready && (lu_rd != 5'd0);

    always_comb begin
        w_pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_fifo_vld[i]) begin
                w_pending[r_fifo_rd[i]] = 1'b1;
            end
        end
        w_pending[0] = 1'b0;
    end
    assign pending_mask = w_pending;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wptr]   <= lu_rd;
            r_fifo_data[r_wptr] <= lu_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fifo_vld <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else begin
            // A pop and a push never hit the same slot: pop needs count != 0, push needs count < DEPTH.
            if (w_pop) begin
                r_fifo_vld[r_rptr] <= 1'b0;
                r_rptr             <= r_rptr + C_PTR_W'(1);
            end
            if (w_push) begin
                r_fifo_vld[r_wptr] <= 1'b1;
                r_wptr             <= r_wptr + C_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CNT_W'(1);
                2'b01:   r_count <= r_count - C_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= '0;
        end else if (w_pop || !w_not_empty) begin
            r_starve <= '0;
        end else if (w_grant_wb && (r_starve != C_STARVE)) begin
            r_starve <= r_starve + C_STV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_rd    <= 5'd0;
            rf_wdata <= 32'd0;
        end else if (w_grant_wb) begin
            rf_we    <= 1'b1;
            rf_rd    <= wb_rd;
            rf_wdata <= wb_data;
        end else if (w_grant_lu) begin
            rf_we    <= 1'b1;
            rf_rd    <= r_fifo_rd[r_rptr];
            rf_wdata <= r_fifo_data[r_rptr];
        end else begin
            rf_we    <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Purpose  : Directed vectors with hand-computed expectations for regfile_write_arbiter.
// Revision : 1.0
// ============================================================================
module tb_regfile_write_arbiter;

    logic        clk;
    logic        rst;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_stall;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic [31:0] pending_mask;

    int n_cmp = 0;
    int n_err = 0;

    regfile_write_arbiter #(
        .DEPTH      (2),
        .STARVE_MAX (4)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_stall     (wb_stall),
        .lu_valid     (lu_valid),
        .lu_rd        (lu_rd),
        .lu_data      (lu_data),
        .lu_ready     (lu_ready),
        .rf_we        (rf_we),
        .rf_rd        (rf_rd),
        .rf_wdata     (rf_wdata),
        .pending_mask (pending_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
        wb_valid = v;
        wb_rd    = rd;
        wb_data  = d;
    endtask

    task automatic set_lu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        lu_valid = v;
        lu_rd    = rd;
        lu_data  = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  lu_idx;
        logic acc;

        rst = 1'b1;
        set_wb(1'b0, 5'd0, 32'd0);
        set_lu(1'b0, 5'd0, 32'd0);
        step();
        step();
        check_eq("rst_lu_ready", {31'd0, lu_ready}, 32'd1);
        check_eq("rst_wb_stall", {31'd0, wb_stall}, 32'd0);
        check_eq("rst_pending",  pending_mask, 32'd0);
        check_eq("rst_rf_we",    {31'd0, rf_we}, 32'd0);
        check_eq("rst_rf_rd",    {27'd0, rf_rd}, 32'd0);
        check_eq("rst_rf_wdata", rf_wdata, 32'd0);
        rst = 1'b0;

        // LU only: push in c0, visible in mask c1, written c2
        set_lu(1'b1, 5'd5, 32'hDEADBEEF);
        step();
        set_lu(1'b0, 5'd0, 32'd0);
        check_eq("lu_pending_c1", pending_mask, 32'h0000_0020);
        check_eq("lu_we_c1",      {31'd0, rf_we}, 32'd0);
        step();
        check_eq("lu_we_c2",      {31'd0, rf_we}, 32'd1);
        check_eq("lu_rd_c2",      {27'd0, rf_rd}, 32'd5);
        check_eq("lu_data_c2",    rf_wdata, 32'hDEADBEEF);
        check_eq("lu_pending_c2", pending_mask, 32'd0);

        // Idle: outputs hold, no stall
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("idle_we",    {31'd0, rf_we}, 32'd0);
            check_eq("idle_rd",    {27'd0, rf_rd}, 32'd5);
            check_eq("idle_data",  rf_wdata, 32'hDEADBEEF);
            check_eq("idle_stall", {31'd0, wb_stall}, 32'd0);
        end

        // Starvation: one LU entry rd7, then WB rd1..6 every cycle
        set_lu(1'b1, 5'd7, 32'h0000_0077);
        step();
        set_lu(1'b0, 5'd0, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            set_wb(1'b1, 5'(k), 32'h100 + 32'(k));
            check_eq("stv_no_stall", {31'd0, wb_stall}, 32'd0);
            check_eq("stv_pending",  pending_mask, 32'h0000_0080);
            step();
            check_eq("stv_wb_we",   {31'd0, rf_we}, 32'd1);
            check_eq("stv_wb_rd",   {27'd0, rf_rd}, 32'(k));
            check_eq("stv_wb_data", rf_wdata, 32'h100 + 32'(k));
        end
        set_wb(1'b1, 5'd5, 32'h105);
        check_eq("stv_stall", {31'd0, wb_stall}, 32'd1);
        step();
        check_eq("stv_drain_rd",   {27'd0, rf_rd}, 32'd7);
        check_eq("stv_drain_data", rf_wdata, 32'h0000_0077);
        check_eq("stv_unstall",    {31'd0, wb_stall}, 32'd0);
        check_eq("stv_pend_clr",   pending_mask, 32'd0);
        step();
        check_eq("stv_resume_rd",   {27'd0, rf_rd}, 32'd5);
        check_eq("stv_resume_data", rf_wdata, 32'h105);
        set_wb(1'b1, 5'd6, 32'h106);
        step();
        check_eq("stv_rd6", {27'd0, rf_rd}, 32'd6);
        set_wb(1'b0, 5'd0, 32'd0);
        step();
        check_eq("stv_idle_we", {31'd0, rf_we}, 32'd0);

        // FIFO full: WB continuous, LU A(10) B(11) C(12)
        lu_idx = 0;
        for (int t = 0; t <= 10; t++) begin
            set_wb(1'b1, 5'd1, 32'(t));
            if (lu_idx < 3) set_lu(1'b1, 5'(10 + lu_idx), 32'hA0 + 32'(lu_idx));
            else            set_lu(1'b0, 5'd0, 32'd0);
            #1;
            if (t == 2) begin
                check_eq("full_ready_c2",   {31'd0, lu_ready}, 32'd0);
                check_eq("full_pending_c2", pending_mask, 32'h0000_0C00);
            end
            if (t == 5) begin
                check_eq("full_stall_c5", {31'd0, wb_stall}, 32'd1);
                check_eq("full_ready_c5", {31'd0, lu_ready}, 32'd0);
            end
            if (t == 6) begin
                check_eq("full_drainA_rd",  {27'd0, rf_rd}, 32'd10);
                check_eq("full_drainA_dat", rf_wdata, 32'h0000_00A0);
                check_eq("full_ready_c6",   {31'd0, lu_ready}, 32'd1);
                check_eq("full_pending_c6", pending_mask, 32'h0000_0800);
            end
            if (t == 7) check_eq("full_pending_c7", pending_mask, 32'h0000_1800);
            if (t == 10) check_eq("full_stall_c10", {31'd0, wb_stall}, 32'd1);
            acc = lu_valid && lu_ready;
            step();
            if (acc) lu_idx++;
        end
        check_eq("full_drainB_rd",  {27'd0, rf_rd}, 32'd11);
        check_eq("full_drainB_dat", rf_wdata, 32'h0000_00A1);
        set_wb(1'b0, 5'd0, 32'd0);
        set_lu(1'b0, 5'd0, 32'd0);
        step();
        check_eq("full_drainC_rd",  {27'd0, rf_rd}, 32'd12);
        check_eq("full_drainC_dat", rf_wdata, 32'h0000_00A2);
        step();
        check_eq("full_empty_pend", pending_mask, 32'd0);

        // x0 discard: WB to x0 lets the queued entry drain
        set_lu(1'b1, 5'd9, 32'h0000_0099);
        step();
        set_lu(1'b0, 5'd0, 32'd0);
        set_wb(1'b1, 5'd0, 32'h0000_0055);
        check_eq("x0_no_stall", {31'd0, wb_stall}, 32'd0);
        step();
        set_wb(1'b0, 5'd0, 32'd0);
        check_eq("x0_we",   {31'd0, rf_we}, 32'd1);
        check_eq("x0_rd",   {27'd0, rf_rd}, 32'd9);
        check_eq("x0_data", rf_wdata, 32'h0000_0099);
        set_lu(1'b1, 5'd0, 32'h0000_0123);
        check_eq("x0_lu_ready", {31'd0, lu_ready}, 32'd1);
        step();
        set_lu(1'b0, 5'd0, 32'd0);
        check_eq("x0_lu_pending", pending_mask, 32'd0);
        check_eq("x0_lu_ready2",  {31'd0, lu_ready}, 32'd1);
        step();
        check_eq("x0_lu_never_we", {31'd0, rf_we}, 32'd0);

        // Reset mid-operation with two queued entries
        set_wb(1'b1, 5'd1, 32'h0000_0011);
        set_lu(1'b1, 5'd3, 32'h0000_0033);
        step();
        set_lu(1'b1, 5'd4, 32'h0000_0044);
        step();
        set_lu(1'b0, 5'd0, 32'd0);
        check_eq("mid_pending_pre", pending_mask, 32'h0000_0018);
        check_eq("mid_ready_pre",   {31'd0, lu_ready}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check_eq("mid_pending", pending_mask, 32'd0);
        check_eq("mid_rf_we",   {31'd0, rf_we}, 32'd0);
        check_eq("mid_ready",   {31'd0, lu_ready}, 32'd1);
        check_eq("mid_stall",   {31'd0, wb_stall}, 32'd0);
        check_eq("mid_rf_rd",   {27'd0, rf_rd}, 32'd0);
        #1;
        rst = 1'b0;
        set_wb(1'b0, 5'd0, 32'd0);
        step();
        check_eq("post_rst_we", {31'd0, rf_we}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
